ifb_feeder: RTL

//  Instruction fetch requester: the producer end of the IFB push interface. Drives AHB-Lite

---
 rtl/p_hardisc.sv | 38 +++
 rtl/seu_regs.sv | 23 ++
 rtl/ifb_feeder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/p_hardisc.sv
// Shared fetch-side types for the hardisc core.
// IFB entry layout, status codes and feeder state.
package p_hardisc;

  localparam int IFB_WIDTH = 38;

  localparam logic [2:0] FETCH_VALID = 3'b000;
  localparam logic [2:0] FETCH_BUSER = 3'b010;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  daddr;
    logic [31:0]  aaddr;
    fetch_state_t state;
    logic         dphase;
    logic         discard;
    logic         redir;
    logic         apend;
  } ifbf_regs_t;

  function automatic int popcount_ifb(input logic [31:0] occ);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(occ[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/seu_regs.sv
// State register bank with synchronous active-low reset.
// Single place where protected builds can harden state.
module seu_regs #(
  parameter string        LABEL  = "REG",
  parameter int           W      = 1,
  parameter logic [W-1:0] RSTVAL = '0
) (
  input  logic         s_clk_i,
  input  logic         s_resetn_i,
  input  logic [W-1:0] s_d_i,
  output logic [W-1:0] s_q_o
);

  // register the whole bank; reset loads RSTVAL
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      s_q_o <= RSTVAL;
    end else begin
      s_q_o <= s_d_i;
    end
  end

endmodule

// File: rtl/ifb_feeder.sv
// Instruction fetch requester feeding the IFB.
// AHB-Lite reads from a sequential PC, credit = IFB occupancy.
module ifb_feeder
  import p_hardisc::*;
#(
  parameter int          SIZE      = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter string       LABEL     = "IFBF"
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic                 s_flush_i,
  input  logic [31:0]          s_flush_addr_i,
  input  logic [SIZE-1:0]      s_ifb_occ_i,
  output logic [31:0]          s_haddr_o,
  output logic [1:0]           s_htrans_o,
  input  logic                 s_hready_i,
  input  logic                 s_hresp_i,
  input  logic [31:0]          s_hrdata_i,
  input  logic [6:0]           s_hchecksum_i,
  output logic                 s_push_o,
  output logic [IFB_WIDTH-1:0] s_data_o,
  output logic [6:0]           s_checksum_o,
  output logic [31:0]          s_fetch_addr_o
);

  localparam ifbf_regs_t RST_V = '{
    pc:      BOOT_ADDR,
    daddr:   32'd0,
    aaddr:   32'd0,
    state:   RUN,
    dphase:  1'b0,
    discard: 1'b0,
    redir:   1'b0,
    apend:   1'b0
  };

  ifbf_regs_t  r_q;
  ifbf_regs_t  r_d;
  int          occ_cnt;
  logic        credit;
  logic        issue;
  logic        nonseq;
  logic        acc;
  logic        dcomp;
  logic        push;
  logic        berr;
  logic [31:0] addr;

  seu_regs #(
    .LABEL  ({LABEL, "_ST"}),
    .W      ($bits(ifbf_regs_t)),
    .RSTVAL (RST_V)
  ) u_regs (
    .s_clk_i    (s_clk_i),
    .s_resetn_i (s_resetn_i),
    .s_d_i      (r_d),
    .s_q_o      (r_q)
  );

  // bus handshake decode; a waiting address phase is held as-is
  always_comb begin
    occ_cnt = popcount_ifb(32'(s_ifb_occ_i));
    credit  = (occ_cnt + int'(r_q.dphase) + 1) <= SIZE;
    issue   = (r_q.state == RUN) & ~r_q.redir & ~r_q.apend
            & ~s_flush_i & credit;
    nonseq  = s_resetn_i & (r_q.apend | issue);
    addr    = r_q.apend ? r_q.aaddr : r_q.pc;
    acc     = nonseq & s_hready_i;
    dcomp   = r_q.dphase & s_hready_i;
    push    = s_resetn_i & dcomp & ~r_q.discard & ~s_flush_i;
    berr    = push & s_hresp_i;
  end

  // next state: pipeline flags, PC advance, redirect and halt
  always_comb begin
    r_d = r_q;
    if (acc) begin
      r_d.apend   = 1'b0;
      r_d.dphase  = 1'b1;
      r_d.daddr   = addr;
      r_d.discard = r_q.redir | s_flush_i | berr;
      r_d.redir   = 1'b0;
      if (!r_q.redir) begin
        r_d.pc = r_q.pc + 32'd4;
      end
    end else begin
      if (nonseq) begin
        r_d.apend = 1'b1;
        r_d.aaddr = addr;
      end
      if (dcomp) begin
        r_d.dphase  = 1'b0;
        r_d.discard = 1'b0;
      end else if (s_flush_i & r_q.dphase) begin
        r_d.discard = 1'b1;
      end
      if (s_flush_i & nonseq) begin
        r_d.redir = 1'b1;
      end
    end
    if (s_flush_i) begin
      r_d.pc    = s_flush_addr_i;
      r_d.state = RUN;
    end else if (berr) begin
      r_d.state = HALT;
    end
  end

  // bus and IFB outputs; data and checksum pass straight through
  always_comb begin
    s_htrans_o     = nonseq ? HT_NONSEQ : HT_IDLE;
    s_haddr_o      = addr;
    s_push_o       = push;
    s_data_o       = {2'b00,
                      s_hresp_i ? FETCH_BUSER : FETCH_VALID,
                      1'b0, s_hrdata_i};
    s_checksum_o   = s_hchecksum_i;
    s_fetch_addr_o = r_q.daddr;
  end

endmodule
